// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_pkg
// Purpose  : Shared definitions for the 5-stage pipeline hazard controller.
//            Contents:
//            - sequencer state encoding
//            - forwarding mux select codes
//            - error vector bit positions
//            - the M-over-WB forwarding priority helper
// Revision : 1.0  initial release
// ============================================================================
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MC_STALL = 2'b01,
      ST_HALT     = 2'b10
   } state_t;

   localparam logic [1:0] HAZ_SEL_RF  = 2'b00;  // operand from register file
   localparam logic [1:0] HAZ_SEL_EXM = 2'b01;  // operand from EX/M result
   localparam logic [1:0] HAZ_SEL_MWB = 2'b10;  // operand from M/WB writeback data

   localparam int ERR_BIT_ALU   = 0;
   localparam int ERR_BIT_CTRL  = 1;
   localparam int ERR_BIT_ADDR  = 2;
   localparam int ERR_BIT_SPARE = 3;

   // The younger producer (in M) holds the newer value, so it beats WB.
   function automatic logic [1:0] fwd_select(input logic m_hit, input logic wb_hit);
      if (m_hit) begin
         return HAZ_SEL_EXM;
      end
      if (wb_hit) begin
         return HAZ_SEL_MWB;
      end
      return HAZ_SEL_RF;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_unit
// Purpose  : Combinational register-address comparators. Produces the two
//            EX-operand forwarding selects and the stall-request flag.
// Config   : HAZ_FWD_EN defined   -> forwarding selects are generated and
//                                     only a load-use pair requests a stall.
//            HAZ_FWD_EN undefined -> selects are tied to the register file
//                                     and any RAW pair against EX or M
//                                     requests a stall.
// Ports    : id_src1/2, ex_src1/2        - source registers in ID and EX
//            ex_dst, m_dst, wb_dst       - destination registers
//            ex_memread, ex_wen, m_wen, wb_wen - control bits
//            haz1_sel, haz2_sel          - forwarding selects (out)
//            hazard                      - stall request (out)
// Revision : 1.0  initial release
// ============================================================================
module hazard_fwd_unit
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_AW = 4
) (
   input  logic [REG_AW-1:0] id_src1,
   input  logic [REG_AW-1:0] id_src2,
   input  logic [REG_AW-1:0] ex_src1,
   input  logic [REG_AW-1:0] ex_src2,
   input  logic [REG_AW-1:0] ex_dst,
   input  logic [REG_AW-1:0] m_dst,
   input  logic [REG_AW-1:0] wb_dst,
   input  logic              ex_memread,
   input  logic              ex_wen,
   input  logic              m_wen,
   input  logic              wb_wen,
   output logic [1:0]        haz1_sel,
   output logic [1:0]        haz2_sel,
   output logic              hazard
);

   logic w_ex_hits_id;
   assign w_ex_hits_id = (ex_dst == id_src1) || (ex_dst == id_src2);

`ifdef HAZ_FWD_EN
   assign haz1_sel = fwd_select(m_wen && (m_dst == ex_src1), wb_wen && (wb_dst == ex_src1));
   assign haz2_sel = fwd_select(m_wen && (m_dst == ex_src2), wb_wen && (wb_dst == ex_src2));

   // Only a load cannot be forwarded in time; everything else uses the muxes.
   assign hazard   = ex_memread && ex_wen && w_ex_hits_id;
`else
   logic w_m_hits_id;
   logic w_unused;

   assign w_m_hits_id = (m_dst == id_src1) || (m_dst == id_src2);
   assign w_unused    = ^{ex_memread, ex_src1, ex_src2, wb_dst, wb_wen};

   assign haz1_sel = HAZ_SEL_RF;
   assign haz2_sel = HAZ_SEL_RF;

   // Without forwarding, the consumer waits until the producer has left M.
   assign hazard   = (ex_wen && w_ex_hits_id) || (m_wen && w_m_hits_id);
`endif

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Central sequencer for the IF/ID/EX/M/WB pipeline.
//            - drives the buffer locks/flushes and the PC hold
//            - forwards the EX-operand selects
//            - keeps the sticky error register
//            - freezes the pipeline on any error
// Config   : HAZ_FWD_EN (see hazard_fwd_unit) selects forwarding versus
//            stall-only RAW handling.
// Ports    : clk, rst (sync, active-high)
//            id_*/ex_*/m_*/wb_* register addresses and control bits
//            ex_branch_taken, ex_mc_start, err_in
//            pc_dis, *_dis, *_flush - pipeline buffer control (out)
//            haz1_sel, haz2_sel     - forwarding selects (out)
//            errors, halted, mc_busy - status (out)
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_AW    = 4,
   parameter int MC_CYCLES = 4,
   parameter int ERR_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_src1,
   input  logic [REG_AW-1:0] id_src2,
   input  logic [REG_AW-1:0] ex_src1,
   input  logic [REG_AW-1:0] ex_src2,
   input  logic [REG_AW-1:0] ex_dst,
   input  logic              ex_memread,
   input  logic              ex_wen,
   input  logic              ex_branch_taken,
   input  logic              ex_mc_start,
   input  logic [REG_AW-1:0] m_dst,
   input  logic [REG_AW-1:0] wb_dst,
   input  logic              m_wen,
   input  logic              wb_wen,
   input  logic [ERR_W-1:0]  err_in,
   output logic              pc_dis,
   output logic              if_id_dis,
   output logic              if_id_flush,
   output logic              id_ex_dis,
   output logic              id_ex_flush,
   output logic              ex_m_dis,
   output logic              ex_m_flush,
   output logic              m_wb_dis,
   output logic [1:0]        haz1_sel,
   output logic [1:0]        haz2_sel,
   output logic [ERR_W-1:0]  errors,
   output logic              halted,
   output logic              mc_busy
);

   localparam int                   c_cnt_w   = $clog2(MC_CYCLES);
   localparam logic [c_cnt_w-1:0]   c_mc_load = c_cnt_w'(MC_CYCLES - 2);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_cnt_w-1:0] r_mc_cnt;
   logic [c_cnt_w-1:0] w_mc_cnt_nxt;
   logic [ERR_W-1:0]   r_errors;

   logic [1:0]         w_haz1;
   logic [1:0]         w_haz2;
   logic               w_hazard;
   logic               w_err;
   logic               w_mc_start;

   hazard_fwd_unit #(
      .REG_AW (REG_AW)
   ) u_hazard_fwd_unit (
      .id_src1    (id_src1),
      .id_src2    (id_src2),
      .ex_src1    (ex_src1),
      .ex_src2    (ex_src2),
      .ex_dst     (ex_dst),
      .m_dst      (m_dst),
      .wb_dst     (wb_dst),
      .ex_memread (ex_memread),
      .ex_wen     (ex_wen),
      .m_wen      (m_wen),
      .wb_wen     (wb_wen),
      .haz1_sel   (w_haz1),
      .haz2_sel   (w_haz2),
      .hazard     (w_hazard)
   );

   assign w_err      = |err_in;
   // An error arriving with the start pulse wins: the op never occupies EX.
   assign w_mc_start = (r_state == ST_RUN) && ex_mc_start && !w_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_RUN;
         r_mc_cnt <= '0;
         r_errors <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_mc_cnt <= w_mc_cnt_nxt;
         r_errors <= r_errors | err_in;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_mc_cnt_nxt = r_mc_cnt;
      pc_dis       = 1'b0;
      if_id_dis    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_dis    = 1'b0;
      id_ex_flush  = 1'b0;
      ex_m_dis     = 1'b0;
      ex_m_flush   = 1'b0;
      m_wb_dis     = 1'b0;
      haz1_sel     = HAZ_SEL_RF;
      haz2_sel     = HAZ_SEL_RF;
      errors       = r_errors;
      halted       = 1'b0;
      mc_busy      = 1'b0;

      case (r_state)
         ST_HALT: begin
            pc_dis    = 1'b1;
            if_id_dis = 1'b1;
            id_ex_dis = 1'b1;
            ex_m_dis  = 1'b1;
            m_wb_dis  = 1'b1;
            halted    = 1'b1;
         end

         ST_MC_STALL: begin
            haz1_sel = w_haz1;
            haz2_sel = w_haz2;
            mc_busy  = 1'b1;
            if (r_mc_cnt != '0) begin
               pc_dis       = 1'b1;
               if_id_dis    = 1'b1;
               id_ex_dis    = 1'b1;
               ex_m_flush   = 1'b1;
               w_mc_cnt_nxt = r_mc_cnt - c_cnt_w'(1);
            end else begin
               // Final cycle: locks drop so the result moves on to M.
               w_state_nxt = ST_RUN;
            end
         end

         default: begin
            haz1_sel = w_haz1;
            haz2_sel = w_haz2;
            if (w_mc_start) begin
               pc_dis       = 1'b1;
               if_id_dis    = 1'b1;
               id_ex_dis    = 1'b1;
               ex_m_flush   = 1'b1;
               mc_busy      = 1'b1;
               w_state_nxt  = ST_MC_STALL;
               w_mc_cnt_nxt = c_mc_load;
            end else if (ex_branch_taken) begin
               // Wrong-path instructions in IF/ID and ID/EX are discarded.
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (w_hazard) begin
               pc_dis      = 1'b1;
               if_id_dis   = 1'b1;
               id_ex_flush = 1'b1;
            end
         end
      endcase

      if (w_err) begin
         w_state_nxt = ST_HALT;
      end

      if (rst) begin
         pc_dis      = 1'b0;
         if_id_dis   = 1'b0;
         if_id_flush = 1'b0;
         id_ex_dis   = 1'b0;
         id_ex_flush = 1'b0;
         ex_m_dis    = 1'b0;
         ex_m_flush  = 1'b0;
         m_wb_dis    = 1'b0;
         haz1_sel    = HAZ_SEL_RF;
         haz2_sel    = HAZ_SEL_RF;
         errors      = '0;
         halted      = 1'b0;
         mc_busy     = 1'b0;
      end
   end

endmodule
`default_nettype wire
